// File: rtl/box_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : box_plot_arbiter
//  Description : Round-robin arbiter sharing one VGA pixel-write port between
//                two box-drawing requesters. The winner's box origin and
//                colour are latched, a SIZE x SIZE raster fill is sequenced
//                onto the plot port with off-screen clipping, and a one-cycle
//                ack is returned when the box is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module box_plot_arbiter #(
    parameter int SIZE_LOG2 = 2,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic       clk,
    input  logic       r_set,
    input  logic       req0,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] c0,
    input  logic       erase0,
    input  logic       req1,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    input  logic [2:0] c1,
    input  logic       erase1,
    output logic [1:0] grant,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_c,
    output logic       plot
);

    // Pixel counter spans one full box: {iy, ix}, ix in the low bits.
    localparam int              c_CNT_W    = 2 * SIZE_LOG2;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = {c_CNT_W{1'b1}};

    // Clip limits sized to the unclipped coordinate sums.
    localparam logic [8:0] c_X_MAX = 9'(X_MAX);
    localparam logic [7:0] c_Y_MAX = 8'(Y_MAX);

    // FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DRAW = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_grant;
    logic               r_prio;     // 0: favour requester 0, 1: favour requester 1
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_bx;
    logic [6:0]         r_by;
    logic [2:0]         r_colour;

    logic               w_win0;
    logic               w_win1;
    logic               w_start;
    logic [SIZE_LOG2-1:0] w_ix;
    logic [SIZE_LOG2-1:0] w_iy;
    logic [8:0]         w_x9;
    logic [7:0]         w_y8;
    logic               w_on_screen;

    // Arbitration: a lone request wins outright; on contention the pointer decides.
    assign w_win0  = req0 & (~req1 | ~r_prio);
    assign w_win1  = req1 & (~req0 |  r_prio);
    assign w_start = (r_state == c_IDLE) & (w_win0 | w_win1);

    // State, grant ownership and round-robin pointer.
    always_ff @(posedge clk or negedge r_set) begin
        if (!r_set) begin
            r_state <= c_IDLE;
            r_grant <= 2'b00;
            r_prio  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state <= c_DRAW;
                        r_grant <= {w_win1, w_win0};
                    end
                end
                c_DRAW: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_grant <= 2'b00;
                    // Whoever was just served loses the next tie.
                    r_prio  <= r_grant[0];
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // Capture the winner's box; erase forces black so the box is wiped.
    always_ff @(posedge clk or negedge r_set) begin
        if (!r_set) begin
            r_bx     <= 8'd0;
            r_by     <= 7'd0;
            r_colour <= 3'd0;
        end else if (w_start) begin
            if (w_win1) begin
                r_bx     <= x1;
                r_by     <= y1;
                r_colour <= erase1 ? 3'b000 : c1;
            end else begin
                r_bx     <= x0;
                r_by     <= y0;
                r_colour <= erase0 ? 3'b000 : c0;
            end
        end
    end

    // Raster pixel counter: cleared on grant, stepped once per DRAW cycle.
    always_ff @(posedge clk or negedge r_set) begin
        if (!r_set) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if ((r_state == c_DRAW) && (r_cnt != c_CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pixel address is formed one bit wider than the port so the clip test
    // sees boxes that run off the right or bottom edge.
    assign w_ix        = r_cnt[SIZE_LOG2-1:0];
    assign w_iy        = r_cnt[c_CNT_W-1:SIZE_LOG2];
    assign w_x9        = {1'b0, r_bx} + {{(9 - SIZE_LOG2){1'b0}}, w_ix};
    assign w_y8        = {1'b0, r_by} + {{(8 - SIZE_LOG2){1'b0}}, w_iy};
    assign w_on_screen = (w_x9 <= c_X_MAX) && (w_y8 <= c_Y_MAX);

    // Pixel port decode from registered state only; quiet outside DRAW.
    always_comb begin
        out_x = 8'd0;
        out_y = 7'd0;
        out_c = 3'd0;
        plot  = 1'b0;
        if (r_state == c_DRAW) begin
            out_x = w_x9[7:0];
            out_y = w_y8[6:0];
            out_c = r_colour;
            plot  = w_on_screen;
        end
    end

    assign grant = r_grant;
    assign ack0  = (r_state == c_DONE) & r_grant[0];
    assign ack1  = (r_state == c_DONE) & r_grant[1];
    assign busy  = (r_state == c_DRAW) | (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_box_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_box_plot_arbiter
//  Description : Self-checking bench for box_plot_arbiter. Table of single
//                and contending requests plus hand-written sequences for
//                back-to-back contention, reset mid-draw and late req drop.
//                Expected pixels are pushed to a scoreboard queue and popped
//                as the DUT draws.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_box_plot_arbiter;

    logic       clk;
    logic       r_set;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    logic       erase0, erase1;
    logic [1:0] grant;
    logic       ack0, ack1, busy, plot;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_c;

    box_plot_arbiter #(.SIZE_LOG2(2), .X_MAX(159), .Y_MAX(119)) dut (
        .clk(clk), .r_set(r_set),
        .req0(req0), .x0(x0), .y0(y0), .c0(c0), .erase0(erase0),
        .req1(req1), .x1(x1), .y1(y1), .c1(c1), .erase1(erase1),
        .grant(grant), .ack0(ack0), .ack1(ack1), .busy(busy),
        .out_x(out_x), .out_y(out_y), .out_c(out_c), .plot(plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    typedef struct {
        logic       r0;
        logic [7:0] vx0;
        logic [6:0] vy0;
        logic [2:0] vc0;
        logic       ve0;
        logic       r1;
        logic [7:0] vx1;
        logic [6:0] vy1;
        logic [2:0] vc1;
        logic       ve1;
        logic [1:0] own;
    } vec_t;

    pix_t sb[$];
    vec_t vt[6];
    int   n_pass  = 0;
    int   n_total = 0;
    int   lat;
    int   lat2;
    logic saw_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model of one box: raster order, x fastest, clip against 159/119.
    task automatic push_box(input logic [7:0] bx, input logic [6:0] by,
                            input logic [2:0] c, input logic e);
        pix_t p;
        int   xx, yy;
        for (int iy = 0; iy < 4; iy++) begin
            for (int ix = 0; ix < 4; ix++) begin
                xx  = int'(bx) + ix;
                yy  = int'(by) + iy;
                p.x = xx[7:0];
                p.y = yy[6:0];
                p.c = e ? 3'b000 : c;
                p.p = (xx <= 159) && (yy <= 119);
                sb.push_back(p);
            end
        end
    endtask

    // Waits (bounded) for a grant, checks 16 pixel cycles against the
    // scoreboard, then checks the DONE/ack cycle. Returns at the ack negedge.
    task automatic expect_box(input logic [1:0] own, output int wait_cycles);
        pix_t e;
        wait_cycles = 0;
        do begin
            @(negedge clk);
            wait_cycles++;
        end while (grant == 2'b00 && wait_cycles < 40);
        if (grant == 2'b00) begin
            check("grant_timeout", {30'd0, grant}, {30'd0, own});
            sb.delete();
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            check("draw_grant", {30'd0, grant}, {30'd0, own});
            check("draw_busy", {31'd0, busy}, 32'd1);
            check("draw_no_ack", {30'd0, ack1, ack0}, 32'd0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got pixel %0d, expected none queued", i);
            end else begin
                e = sb.pop_front();
                check("out_x", {24'd0, out_x}, {24'd0, e.x});
                check("out_y", {25'd0, out_y}, {25'd0, e.y});
                check("out_c", {29'd0, out_c}, {29'd0, e.c});
                check("plot",  {31'd0, plot},  {31'd0, e.p});
            end
        end
        @(negedge clk);
        check("ack0", {31'd0, ack0}, {31'd0, own[0]});
        check("ack1", {31'd0, ack1}, {31'd0, own[1]});
        check("done_plot", {31'd0, plot}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_idle();
        check("idle_grant", {30'd0, grant}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_plot", {31'd0, plot}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // {r0,x0,y0,c0,e0, r1,x1,y1,c1,e1, expected owner}
        vt[0] = '{1'b1, 8'd10,  7'd20,  3'd5, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 2'b01};
        vt[1] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1, 8'd40,  7'd30,  3'd7, 1'b1, 2'b10};
        vt[2] = '{1'b1, 8'd158, 7'd118, 3'd3, 1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 2'b01};
        vt[3] = '{1'b1, 8'd5,   7'd5,   3'd1, 1'b0, 1'b1, 8'd200, 7'd100, 3'd6, 1'b0, 2'b10};
        vt[4] = '{1'b1, 8'd255, 7'd127, 3'd4, 1'b0, 1'b1, 8'd7,   7'd7,   3'd2, 1'b0, 2'b01};
        vt[5] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b1, 8'd0,   7'd0,   3'd2, 1'b0, 2'b10};

        r_set = 1'b0;
        req0 = 1'b0; x0 = '0; y0 = '0; c0 = '0; erase0 = 1'b0;
        req1 = 1'b0; x1 = '0; y1 = '0; c1 = '0; erase1 = 1'b0;
        repeat (2) @(negedge clk);
        check_idle();
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_out_x", {24'd0, out_x}, 32'd0);
        check("rst_out_y", {25'd0, out_y}, 32'd0);
        check("rst_out_c", {29'd0, out_c}, 32'd0);
        r_set = 1'b1;
        @(negedge clk);
        check_idle();

        // Table-driven single and contending requests.
        for (int v = 0; v < 6; v++) begin
            req0 = vt[v].r0; x0 = vt[v].vx0; y0 = vt[v].vy0; c0 = vt[v].vc0; erase0 = vt[v].ve0;
            req1 = vt[v].r1; x1 = vt[v].vx1; y1 = vt[v].vy1; c1 = vt[v].vc1; erase1 = vt[v].ve1;
            if (vt[v].own[0]) push_box(vt[v].vx0, vt[v].vy0, vt[v].vc0, vt[v].ve0);
            else              push_box(vt[v].vx1, vt[v].vy1, vt[v].vc1, vt[v].ve1);
            expect_box(vt[v].own, lat);
            check("latency", lat, 32'd1);
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            check_idle();
        end

        // Contention from reset: both held continuously, order 0,1,0,1.
        r_set = 1'b0;
        req0 = 1'b1; x0 = 8'd20; y0 = 7'd10; c0 = 3'd1; erase0 = 1'b0;
        req1 = 1'b1; x1 = 8'd60; y1 = 7'd50; c1 = 3'd6; erase1 = 1'b0;
        @(negedge clk);
        check_idle();
        r_set = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_box(x0, y0, c0, erase0);
            else            push_box(x1, y1, c1, erase1);
            expect_box((k % 2 == 0) ? 2'b01 : 2'b10, lat);
            check("rr_latency", lat, (k == 0) ? 32'd1 : 32'd2);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check_idle();

        // Reset during pixel 6 of a requester-1 box.
        req1 = 1'b1; x1 = 8'd30; y1 = 7'd40; c1 = 3'd3; erase1 = 1'b0;
        @(negedge clk);
        check("abort_grant", {30'd0, grant}, 32'd2);
        repeat (6) @(negedge clk);
        check("abort_px6_x", {24'd0, out_x}, 32'd32);
        check("abort_px6_y", {25'd0, out_y}, 32'd41);
        #2 r_set = 1'b0;
        #1;
        check("async_plot", {31'd0, plot}, 32'd0);
        check("async_grant", {30'd0, grant}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        req0 = 1'b1; x0 = 8'd70; y0 = 7'd80; c0 = 3'd2; erase0 = 1'b0;
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_ack = saw_ack | ack1 | ack0;
        end
        check("abort_no_ack", {31'd0, saw_ack}, 32'd0);
        r_set = 1'b1;
        push_box(x0, y0, c0, erase0);
        expect_box(2'b01, lat);
        check("post_rst_latency", lat, 32'd1);
        req0 = 1'b0;
        push_box(x1, y1, c1, erase1);
        expect_box(2'b10, lat);
        check("post_rst_rr_latency", lat, 32'd2);
        req1 = 1'b0;
        @(negedge clk);
        check_idle();

        // Late drop of req0: repeat transaction; req1 raised mid-DRAW goes next.
        req0 = 1'b1; x0 = 8'd100; y0 = 7'd60; c0 = 3'd6; erase0 = 1'b0;
        push_box(x0, y0, c0, erase0);
        expect_box(2'b01, lat);
        check("late_first_latency", lat, 32'd1);
        push_box(8'd100, 7'd60, 3'd6, 1'b0);
        fork
            expect_box(2'b01, lat2);
            begin
                @(negedge clk);
                @(negedge clk);
                req0 = 1'b0;
                repeat (5) @(negedge clk);
                x0 = 8'd3; y0 = 7'd3; c0 = 3'd1;
                req1 = 1'b1; x1 = 8'd90; y1 = 7'd90; c1 = 3'd4; erase1 = 1'b0;
            end
        join
        check("late_repeat_latency", lat2, 32'd2);
        push_box(8'd90, 7'd90, 3'd4, 1'b0);
        expect_box(2'b10, lat);
        check("late_req1_latency", lat, 32'd2);
        req1 = 1'b0;
        @(negedge clk);
        check_idle();
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
